// File: rtl/mips_pipe_pkg.sv
// Shared types and encodings for the MIPS pipeline forwarding/hazard slice.
// Holds forward-select codes, register address width and the stage shadow type.
package mips_pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef logic [REG_AW-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    logic regwrite;
    logic memread;
  } stage_dst_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side request and control-response bundle of the forwarding/hazard unit.
// slave: controller side (id_*, flush, mem_stall in; selects, enables, count out).
interface fwd_hazard_ctrl_if
  import mips_pipe_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             id_valid;
  reg_t             id_rs;
  reg_t             id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  reg_t             id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;
  logic             mem_stall;
  logic [1:0]       fwd_op1;
  logic [1:0]       fwd_op2;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt,
    output id_rd, id_regwrite, id_memread,
    output flush, mem_stall,
    input  fwd_op1, fwd_op2,
    input  pc_write_en, if_id_write_en,
    input  id_ex_bubble, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt,
    input  id_rd, id_regwrite, id_memread,
    input  flush, mem_stall,
    output fwd_op1, fwd_op2,
    output pc_write_en, if_id_write_en,
    output id_ex_bubble, stall_cnt
  );

endinterface

// File: rtl/fwd_sel_calc.sv
// Forward select for one ID operand against the EXE and MEM shadows.
// Ports: used/id_x operand, ex shadow, mem shadow fields; sel is the 2-bit select.
module fwd_sel_calc
  import mips_pipe_pkg::*;
(
  input  logic       used,
  input  reg_t       id_x,
  input  stage_dst_t ex,
  input  logic       mem_valid,
  input  reg_t       mem_rd,
  input  logic       mem_regwrite,
  output logic [1:0] sel
);

  logic ex_hit;
  logic mem_hit;

  // A load in EXE has no result yet; that case is a load-use stall.
  assign ex_hit = used & ex.valid
                & ex.regwrite & ~ex.memread
                & (ex.rd != '0)
                & (ex.rd == id_x);

  assign mem_hit = used & mem_valid
                 & mem_regwrite
                 & (mem_rd != '0)
                 & (mem_rd == id_x);

  // Newer EXE result wins over older MEM result.
  always_comb begin
    sel = FWD_IDEX;
    unique case (1'b1)
      ex_hit:            sel = FWD_EXMEM;
      mem_hit & ~ex_hit: sel = FWD_WB;
      default:           sel = FWD_IDEX;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller with EXE/MEM shadow registers.
// Ports: clk, rst (sync, active high), bus (slave side of fwd_hazard_ctrl_if).
module fwd_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input logic              clk,
  input logic              rst,
  fwd_hazard_ctrl_if.slave bus
);

  stage_dst_t       ex;
  logic             mem_valid;
  reg_t             mem_rd;
  logic             mem_regwrite;
  logic [1:0]       op1_q;
  logic [1:0]       op2_q;
  logic [CNT_W-1:0] cnt_q;

  logic       load_use;
  logic       stall;
  logic       bubble;
  logic [1:0] op1_nxt;
  logic [1:0] op2_nxt;

  assign load_use = bus.id_valid & ex.valid
                  & ex.memread & ex.regwrite
                  & (ex.rd != '0)
                  & ((bus.id_use_rs & (bus.id_rs == ex.rd))
                   | (bus.id_use_rt & (bus.id_rt == ex.rd)));

  // A taken branch squashes the consumer, so no stall is needed.
  assign stall  = load_use & ~bus.flush;
  assign bubble = (load_use | bus.flush | ~bus.id_valid)
                & ~bus.mem_stall;

  assign bus.pc_write_en    = ~stall & ~bus.mem_stall;
  assign bus.if_id_write_en = ~stall & ~bus.mem_stall;
  assign bus.id_ex_bubble   = bubble;
  assign bus.fwd_op1        = op1_q;
  assign bus.fwd_op2        = op2_q;
  assign bus.stall_cnt      = cnt_q;

  fwd_sel_calc u_sel_rs (
    .used         (bus.id_use_rs),
    .id_x         (bus.id_rs),
    .ex           (ex),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .sel          (op1_nxt)
  );

  fwd_sel_calc u_sel_rt (
    .used         (bus.id_use_rt),
    .id_x         (bus.id_rt),
    .ex           (ex),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .sel          (op2_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex           <= '0;
      mem_valid    <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      op1_q        <= FWD_IDEX;
      op2_q        <= FWD_IDEX;
      cnt_q        <= '0;
    end else if (!bus.mem_stall) begin
      mem_valid    <= ex.valid;
      mem_rd       <= ex.rd;
      mem_regwrite <= ex.regwrite;
      if (bubble) begin
        ex    <= '0;
        op1_q <= FWD_IDEX;
        op2_q <= FWD_IDEX;
      end else begin
        ex.valid    <= 1'b1;
        ex.rd       <= bus.id_rd;
        ex.regwrite <= bus.id_regwrite;
        ex.memread  <= bus.id_memread;
        op1_q       <= op1_nxt;
        op2_q       <= op2_nxt;
      end
      if (stall && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Random-stimulus bench for fwd_hazard_ctrl against an instruction-level model.
// Narrow stall counter so saturation is reached during the run.
module tb_fwd_hazard_ctrl;
  import mips_pipe_pkg::*;

  localparam int CW   = 4;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  fwd_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  instr_t m_ex;
  instr_t m_mem;
  int     e_op1;
  int     e_op2;
  int     e_cnt;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Which stage supplies operand register r: EXE ALU result (2),
  // value being written back (1), or the register file (0).
  function automatic int src_of(bit used, int r);
    if (!used || r == 0) return 0;
    if (m_ex.v && m_ex.rw && !m_ex.mr && m_ex.rd == r) return 2;
    if (m_mem.v && m_mem.rw && m_mem.rd == r) return 1;
    return 0;
  endfunction

  initial begin
    bit hold;
    bit lu;
    bit e_en;
    bit e_bub;
    int n1;
    int n2;
    instr_t nx_ex;
    instr_t nx_mem;
    int nx_op1;
    int nx_op2;
    int nx_cnt;

    bus.id_valid    = 0;
    bus.id_rs       = '0;
    bus.id_rt       = '0;
    bus.id_use_rs   = 0;
    bus.id_use_rt   = 0;
    bus.id_rd       = '0;
    bus.id_regwrite = 0;
    bus.id_memread  = 0;
    bus.flush       = 0;
    bus.mem_stall   = 0;
    m_ex  = '{0, 0, 0, 0};
    m_mem = '{0, 0, 0, 0};
    e_op1 = 0;
    e_op2 = 0;
    e_cnt = 0;
    hold  = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_op1", int'(bus.fwd_op1), 0);
    chk("rst_op2", int'(bus.fwd_op2), 0);
    chk("rst_cnt", int'(bus.stall_cnt), 0);
    chk("rst_pcw", int'(bus.pc_write_en), 1);
    chk("rst_bub", int'(bus.id_ex_bubble), 1);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) < 2);
      if (!hold) begin
        bus.id_valid    = ($urandom_range(0, 99) < 85);
        bus.id_rs       = reg_t'($urandom_range(0, 3));
        bus.id_rt       = reg_t'($urandom_range(0, 3));
        bus.id_use_rs   = ($urandom_range(0, 99) < 80);
        bus.id_use_rt   = ($urandom_range(0, 99) < 60);
        bus.id_rd       = reg_t'($urandom_range(0, 3));
        bus.id_regwrite = ($urandom_range(0, 99) < 80);
        bus.id_memread  = bus.id_regwrite
                        && ($urandom_range(0, 99) < 40);
      end
      bus.flush     = ($urandom_range(0, 99) < 10);
      bus.mem_stall = ($urandom_range(0, 99) < 15);
      #1;

      lu = bus.id_valid && m_ex.v && m_ex.mr && m_ex.rw
        && m_ex.rd != 0
        && ((bus.id_use_rs && int'(bus.id_rs) == m_ex.rd)
         || (bus.id_use_rt && int'(bus.id_rt) == m_ex.rd));
      e_en  = !(lu && !bus.flush) && !bus.mem_stall;
      e_bub = (lu || bus.flush || !bus.id_valid) && !bus.mem_stall;
      chk("pc_we", int'(bus.pc_write_en), int'(e_en));
      chk("ifid_we", int'(bus.if_id_write_en), int'(e_en));
      chk("bubble", int'(bus.id_ex_bubble), int'(e_bub));

      nx_ex  = m_ex;
      nx_mem = m_mem;
      nx_op1 = e_op1;
      nx_op2 = e_op2;
      nx_cnt = e_cnt;
      if (rst) begin
        nx_ex.v  = 0;
        nx_mem.v = 0;
        nx_op1   = 0;
        nx_op2   = 0;
        nx_cnt   = 0;
      end else if (!bus.mem_stall) begin
        n1 = src_of(bus.id_use_rs, int'(bus.id_rs));
        n2 = src_of(bus.id_use_rt, int'(bus.id_rt));
        nx_mem = m_ex;
        if (e_bub) begin
          nx_ex  = '{0, 0, 0, 0};
          nx_op1 = 0;
          nx_op2 = 0;
        end else begin
          nx_ex  = '{1, int'(bus.id_rd),
                     bus.id_regwrite, bus.id_memread};
          nx_op1 = n1;
          nx_op2 = n2;
        end
        if (lu && !bus.flush && e_cnt < (1 << CW) - 1)
          nx_cnt = e_cnt + 1;
      end
      hold = !e_en && !rst;

      @(posedge clk);
      #1;
      m_ex  = nx_ex;
      m_mem = nx_mem;
      e_op1 = nx_op1;
      e_op2 = nx_op2;
      e_cnt = nx_cnt;
      chk("fwd_op1", int'(bus.fwd_op1), e_op1);
      chk("fwd_op2", int'(bus.fwd_op2), e_op2);
      chk("stall_cnt", int'(bus.stall_cnt), e_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
